nx_indirect_access_cntrl_v3: RTL and testbench
==============================================

# nx_indirect_access_cntrl_v3

Parametrised indirect-access controller that turns CSR command writes into single-entry or sweep accesses on one of N_TABLES memories. It sits between the CSR block and the memory wrappers and arbitrates per-table access through a grant/rsp handshake. Compared with v2 it adds:
- per-table chip selects and per-table RESET/INIT sweeps;
- an auto-incrementing access pointer (READ_INC/WRITE_INC) with wrap at the table limit;
- a saturating error counter.

## Interface
- MEM_TYPE, 0: memory type code; 0 = REG (no powerdown, RESET completes in 1 cycle).
- CMND_ADDRESS, 0: CSR address of the command register.
- N_TIMER_BITS, 6: grant-timeout counter width.
- N_REG_ADDR_BITS, 16: CSR address width.
- N_DATA_BITS, 32: entry width.
- N_TABLES, 4: number of tables (≥1).
- N_ENTRIES, 1024: entries per table (address width AW = clog2(N_ENTRIES), min 1).
- N_ERR_BITS, 8: error-counter width.
- RESET_DATA, 0: data written by RESET and reset value of rd_dat.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- wr_stb  in  1  CSR write strobe.
- reg_addr  in  N_REG_ADDR_BITS  CSR address.
- cmnd_op  in  4  opcode.
- cmnd_addr  in  AW  entry address / sweep end / pointer load value.
- cmnd_table_id  in  clog2(N_TABLES)  target table.
- addr_limit  in  N_TABLES×AW  per-table last valid address.
- wr_dat  in  N_DATA_BITS  write data / INIT_INC seed.
- stat_code  out  3  RDY=0 BSY=1 TMO=2 OVR=3 NXM=4 UOP=5 PDN=7.
- stat_ptr  out  AW  current pointer.
- err_cnt  out  N_ERR_BITS  saturating count of ERROR entries.
- enable  out  1  high when not in POWERDOWN.
- rd_dat  out  N_DATA_BITS  read / compare result.
- sw_cs  out  N_TABLES  one-hot chip select.
- sw_we  out  1  write enable.
- sw_ce  out  1  compare enable.
- sw_add  out  AW  memory address.
- sw_wdat  out  N_DATA_BITS  write data.
- sw_rdat  in  N_DATA_BITS  read data.
- sw_match  in  1  compare hit.
- sw_aindex  in  AW  compare hit index.
- grant  in  1  access accepted this cycle.
- rsp  in  1  read/compare data valid.
- yield  out  1  MSB of the timeout timer.
- reset  out  1  high during RESET sweep cycles.

## Operation
- A command is issued when wr_stb && reg_addr==CMND_ADDRESS && op∉{NOP, SIM_TMO}.
- Opcodes:
  - 0 NOP, 1 READ, 2 WRITE, 3 ENABLE, 4 DISABLE, 5 RESET, 6 INIT, 7 INIT_INC, 8 SET_INIT_START, 9 COMPARE;
  - A SET_PTR: ptr=cmnd_addr, stays READY;
  - B READ_INC, C WRITE_INC;
  - E SIM_TMO: suppress grant until the next timeout;
  - F ACK_ERROR;
  - any other opcode → ERROR/UOP.
- States: POWERDOWN, READY, ERROR, DO_RESET, DO_INIT, DO_WRITE, DO_READ, READ_DONE, DO_COMPARE, COMPARE_DONE.
- POWERDOWN (reset state unless MEM_TYPE==REG): only ENABLE → READY.
- From READY:
  - WRITE/WRITE_INC → DO_WRITE;
  - READ/READ_INC → DO_READ;
  - COMPARE → DO_COMPARE;
  - RESET → DO_RESET with sweep addr=0;
  - INIT/INIT_INC → DO_INIT from the SET_INIT_START address;
  - DISABLE → POWERDOWN.
- Table latching: the table id is latched at issue. sw_cs has only that bit set while in a DO_* state; other tables are untouched.
- Addressing: sw_add is the sweep address in DO_RESET/DO_INIT, ptr for *_INC ops, otherwise cmnd_addr.
- After a *_INC access is granted, ptr = (ptr==addr_limit[tid]) ? 0 : ptr+1.
- NXM check: if the access address (ptr for *_INC) exceeds addr_limit[tid], the controller goes to ERROR/NXM and no access occurs.
- DO_RESET: sw_wdat=RESET_DATA. The sweep advances on grant and ends after granting addr_limit[tid].
- DO_INIT: sw_wdat=wr_dat, or the incrementing seed for INIT_INC. The sweep ends after granting cmnd_addr.
- Read data: READ_DONE captures rd_dat=sw_rdat on rsp. COMPARE_DONE captures rd_dat={sw_match, sw_aindex}, zero-extended.
- Error conditions → ERROR:
  - a command issued while not in POWERDOWN/READY/ERROR → OVR;
  - the timer reaching all-ones → TMO.
- Errors are priority-coded UOP>NXM>TMO>OVR. Only the first error code is held.
- err_cnt increments on each entry into ERROR and saturates.
- ACK_ERROR → POWERDOWN if the controller was disabled, else READY.

## Timing
- Reset values: stat_code=PDN (RDY if REG), enable=0 (1 if REG), rd_dat=RESET_DATA, sw_cs=0, sw_we=0, sw_ce=0, reset=0, yield=0, err_cnt=0, stat_ptr=0.
- All outputs are registered except sw_add and sw_wdat, which are combinational from registered state.
- Command in cycle T: stat_code=BSY and sw_cs valid at T+1.
- Grant handling:
  - grant in cycle G ends the access; write → RDY at G+1;
  - read → READ_DONE at G+1, then rd_dat valid and RDY one cycle after rsp.
- Timer: increments each busy cycle without grant and clears on grant.
- rst asserted mid-sweep aborts the sweep immediately.
- Simultaneous SET_PTR and wrap cannot occur, because SET_PTR is accepted only in READY.

## Test plan
- Reset, then ENABLE → stat_code 7→0, enable=1; WRITE tbl2 addr5 0xA5 with grant at T+1 → sw_cs=4'b0100, sw_we=1 for 1 cycle, RDY at T+2.
- RESET tbl1 with addr_limit=3 and grant always high → 4 writes of RESET_DATA at addrs 0..3, reset=1 for exactly 4 cycles, other sw_cs bits stay 0.
- SET_PTR 2 with limit 3, then three WRITE_INC → addresses 2, 3, 0; stat_ptr=1.
- READ addr 9 with limit 7 → stat_code=4, err_cnt=1; ACK_ERROR → stat_code=0.
- SIM_TMO then READ, grant high → no grant taken, TMO after 63 busy cycles, yield high from cycle 32.
- WRITE issued during DO_READ → stat_code=3 (OVR); err_cnt saturates at 255 after repeated errors.

Source files
------------

// File: rtl/nx_indirect_access_cntrl_v3.sv
// Indirect-access controller: turns CSR command writes into single or sweep
// accesses on one of N_TABLES memories via a grant/rsp handshake.
module nx_indirect_access_cntrl_v3 #(
    parameter int unsigned MEM_TYPE        = 0,
    parameter int unsigned CMND_ADDRESS    = 0,
    parameter int unsigned N_TIMER_BITS    = 6,
    parameter int unsigned N_REG_ADDR_BITS = 16,
    parameter int unsigned N_DATA_BITS     = 32,
    parameter int unsigned N_TABLES        = 4,
    parameter int unsigned N_ENTRIES       = 1024,
    parameter int unsigned N_ERR_BITS      = 8,
    parameter logic [N_DATA_BITS-1:0] RESET_DATA = '0,
    localparam int unsigned AW = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1,
    localparam int unsigned TW = (N_TABLES > 1) ? $clog2(N_TABLES) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_stb,
    input  logic [N_REG_ADDR_BITS-1:0] reg_addr,
    input  logic [3:0]                 cmnd_op,
    input  logic [AW-1:0]              cmnd_addr,
    input  logic [TW-1:0]              cmnd_table_id,
    input  logic [N_TABLES*AW-1:0]     addr_limit,
    input  logic [N_DATA_BITS-1:0]     wr_dat,
    output logic [2:0]                 stat_code,
    output logic [AW-1:0]              stat_ptr,
    output logic [N_ERR_BITS-1:0]      err_cnt,
    output logic                       enable,
    output logic [N_DATA_BITS-1:0]     rd_dat,
    output logic [N_TABLES-1:0]        sw_cs,
    output logic                       sw_we,
    output logic                       sw_ce,
    output logic [AW-1:0]              sw_add,
    output logic [N_DATA_BITS-1:0]     sw_wdat,
    input  logic [N_DATA_BITS-1:0]     sw_rdat,
    input  logic                       sw_match,
    input  logic [AW-1:0]              sw_aindex,
    input  logic                       grant,
    input  logic                       rsp,
    output logic                       yield,
    output logic                       reset
);

    localparam logic [3:0] OP_NOP        = 4'h0;
    localparam logic [3:0] OP_READ       = 4'h1;
    localparam logic [3:0] OP_WRITE      = 4'h2;
    localparam logic [3:0] OP_ENABLE     = 4'h3;
    localparam logic [3:0] OP_DISABLE    = 4'h4;
    localparam logic [3:0] OP_RESET      = 4'h5;
    localparam logic [3:0] OP_INIT       = 4'h6;
    localparam logic [3:0] OP_INIT_INC   = 4'h7;
    localparam logic [3:0] OP_SET_INIT   = 4'h8;
    localparam logic [3:0] OP_COMPARE    = 4'h9;
    localparam logic [3:0] OP_SET_PTR    = 4'hA;
    localparam logic [3:0] OP_READ_INC   = 4'hB;
    localparam logic [3:0] OP_WRITE_INC  = 4'hC;
    localparam logic [3:0] OP_RSVD       = 4'hD;
    localparam logic [3:0] OP_SIM_TMO    = 4'hE;
    localparam logic [3:0] OP_ACK_ERROR  = 4'hF;

    localparam logic [2:0] ST_RDY = 3'd0;
    localparam logic [2:0] ST_BSY = 3'd1;
    localparam logic [2:0] ST_TMO = 3'd2;
    localparam logic [2:0] ST_OVR = 3'd3;
    localparam logic [2:0] ST_NXM = 3'd4;
    localparam logic [2:0] ST_UOP = 3'd5;
    localparam logic [2:0] ST_PDN = 3'd7;

    // Timeout fires on the busy cycle that would take the timer to all-ones.
    localparam logic [N_TIMER_BITS-1:0] TMO_AT = {{(N_TIMER_BITS-1){1'b1}}, 1'b0};

    typedef enum logic [3:0] {
        StPowerdown, StReady, StError, StDoReset, StDoInit,
        StDoWrite, StDoRead, StReadDone, StDoCompare, StCompareDone
    } state_t;

    state_t                  state;
    logic [TW-1:0]           tid;
    logic [AW-1:0]           addr_lat;
    logic [AW-1:0]           sweep;
    logic [AW-1:0]           init_start;
    logic [AW-1:0]           ptr;
    logic [N_DATA_BITS-1:0]  wdat;
    logic [N_TIMER_BITS-1:0] timer;
    logic                    inc_mode;
    logic                    seed_mode;
    logic                    sim_tmo;

    logic          cmd_hit, issue, gnt, busy, in_access, step, is_inc_op, needs_chk, err_req;
    logic [2:0]    err_code;
    logic [AW-1:0] acc_addr, lim_new, lim_cur;

    function automatic logic [AW-1:0] limit_of(input logic [TW-1:0] t,
                                               input logic [N_TABLES*AW-1:0] lims);
        logic [AW-1:0] l;
        l = '0;
        for (int i = 0; i < N_TABLES; i++) begin
            if (t == TW'(i)) l = lims[i*AW +: AW];
        end
        return l;
    endfunction

    function automatic logic [N_TABLES-1:0] cs_of(input logic [TW-1:0] t);
        logic [N_TABLES-1:0] cs;
        for (int i = 0; i < N_TABLES; i++) cs[i] = (t == TW'(i));
        return cs;
    endfunction

    assign cmd_hit   = wr_stb && (reg_addr == N_REG_ADDR_BITS'(CMND_ADDRESS));
    assign issue     = cmd_hit && (cmnd_op != OP_NOP) && (cmnd_op != OP_SIM_TMO);
    assign gnt       = grant && !sim_tmo;
    assign in_access = state inside {StDoReset, StDoInit, StDoWrite, StDoRead, StDoCompare};
    assign busy      = in_access || (state == StReadDone) || (state == StCompareDone);
    assign step      = in_access ? gnt : rsp;
    assign is_inc_op = (cmnd_op == OP_READ_INC) || (cmnd_op == OP_WRITE_INC);
    assign needs_chk = cmnd_op inside {OP_READ, OP_WRITE, OP_COMPARE, OP_INIT, OP_INIT_INC,
                                       OP_READ_INC, OP_WRITE_INC};
    assign acc_addr  = is_inc_op ? ptr : cmnd_addr;
    assign lim_new   = limit_of(cmnd_table_id, addr_limit);
    assign lim_cur   = limit_of(tid, addr_limit);
    assign stat_ptr  = ptr;
    assign yield     = timer[N_TIMER_BITS-1];

    // Error sources in priority order UOP > NXM > TMO > OVR.
    always_comb begin
        err_req  = 1'b1;
        err_code = ST_UOP;
        if (issue && cmnd_op == OP_RSVD && state != StError) begin
            err_code = ST_UOP;
        end else if (issue && state == StReady && needs_chk && acc_addr > lim_new) begin
            err_code = ST_NXM;
        end else if (busy && !step && timer == TMO_AT) begin
            err_code = ST_TMO;
        end else if (issue && busy) begin
            err_code = ST_OVR;
        end else begin
            err_req  = 1'b0;
            err_code = ST_RDY;
        end
    end

    always_comb begin
        sw_add = addr_lat;
        if (state == StDoReset || state == StDoInit) sw_add = sweep;
        else if (inc_mode) sw_add = ptr;
    end

    assign sw_wdat = (state == StDoReset) ? RESET_DATA : wdat;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= (MEM_TYPE == 0) ? StReady : StPowerdown;
            stat_code  <= (MEM_TYPE == 0) ? ST_RDY : ST_PDN;
            enable     <= (MEM_TYPE == 0);
            rd_dat     <= RESET_DATA;
            sw_cs      <= '0;
            sw_we      <= 1'b0;
            sw_ce      <= 1'b0;
            reset      <= 1'b0;
            err_cnt    <= '0;
            ptr        <= '0;
            tid        <= '0;
            addr_lat   <= '0;
            sweep      <= '0;
            init_start <= '0;
            wdat       <= '0;
            timer      <= '0;
            inc_mode   <= 1'b0;
            seed_mode  <= 1'b0;
            sim_tmo    <= 1'b0;
        end else begin
            timer <= (busy && !step && !err_req) ? timer + N_TIMER_BITS'(1) : '0;
            if (cmd_hit && cmnd_op == OP_SIM_TMO) sim_tmo <= 1'b1;

            if (err_req) begin
                state     <= StError;
                stat_code <= err_code;
                if (err_cnt != '1) err_cnt <= err_cnt + N_ERR_BITS'(1);
                sw_cs     <= '0;
                sw_we     <= 1'b0;
                sw_ce     <= 1'b0;
                reset     <= 1'b0;
                if (err_code == ST_TMO) sim_tmo <= 1'b0;
            end else begin
                unique case (state)
                    StPowerdown: begin
                        if (issue && cmnd_op == OP_ENABLE) begin
                            state     <= StReady;
                            stat_code <= ST_RDY;
                            enable    <= 1'b1;
                        end
                    end
                    StReady: begin
                        if (issue) begin
                            tid       <= cmnd_table_id;
                            addr_lat  <= cmnd_addr;
                            wdat      <= wr_dat;
                            inc_mode  <= is_inc_op;
                            seed_mode <= (cmnd_op == OP_INIT_INC);
                            case (cmnd_op)
                                OP_WRITE, OP_WRITE_INC: begin
                                    state     <= StDoWrite;
                                    stat_code <= ST_BSY;
                                    sw_cs     <= cs_of(cmnd_table_id);
                                    sw_we     <= 1'b1;
                                end
                                OP_READ, OP_READ_INC: begin
                                    state     <= StDoRead;
                                    stat_code <= ST_BSY;
                                    sw_cs     <= cs_of(cmnd_table_id);
                                end
                                OP_COMPARE: begin
                                    state     <= StDoCompare;
                                    stat_code <= ST_BSY;
                                    sw_cs     <= cs_of(cmnd_table_id);
                                    sw_ce     <= 1'b1;
                                end
                                OP_RESET: begin
                                    state     <= StDoReset;
                                    stat_code <= ST_BSY;
                                    sw_cs     <= cs_of(cmnd_table_id);
                                    sw_we     <= 1'b1;
                                    reset     <= 1'b1;
                                    sweep     <= '0;
                                end
                                OP_INIT, OP_INIT_INC: begin
                                    state     <= StDoInit;
                                    stat_code <= ST_BSY;
                                    sw_cs     <= cs_of(cmnd_table_id);
                                    sw_we     <= 1'b1;
                                    sweep     <= init_start;
                                end
                                OP_DISABLE: begin
                                    state     <= StPowerdown;
                                    stat_code <= ST_PDN;
                                    enable    <= 1'b0;
                                end
                                OP_SET_INIT: init_start <= cmnd_addr;
                                OP_SET_PTR:  ptr        <= cmnd_addr;
                                default: ;
                            endcase
                        end
                    end
                    StError: begin
                        if (issue && cmnd_op == OP_ACK_ERROR) begin
                            state     <= enable ? StReady : StPowerdown;
                            stat_code <= enable ? ST_RDY : ST_PDN;
                        end
                    end
                    StDoWrite, StDoRead, StDoCompare: begin
                        if (gnt) begin
                            if (inc_mode) ptr <= (ptr == lim_cur) ? '0 : ptr + AW'(1);
                            sw_cs <= '0;
                            sw_we <= 1'b0;
                            sw_ce <= 1'b0;
                            if (state == StDoWrite) begin
                                state     <= StReady;
                                stat_code <= ST_RDY;
                            end else if (state == StDoRead) begin
                                state <= StReadDone;
                            end else begin
                                state <= StCompareDone;
                            end
                        end
                    end
                    StReadDone: begin
                        if (rsp) begin
                            rd_dat    <= sw_rdat;
                            state     <= StReady;
                            stat_code <= ST_RDY;
                        end
                    end
                    StCompareDone: begin
                        if (rsp) begin
                            rd_dat    <= N_DATA_BITS'({sw_match, sw_aindex});
                            state     <= StReady;
                            stat_code <= ST_RDY;
                        end
                    end
                    StDoReset, StDoInit: begin
                        // INIT also stops at the table limit so a bad start cannot run away.
                        if (gnt) begin
                            if (sweep == lim_cur || (state == StDoInit && sweep == addr_lat)) begin
                                state     <= StReady;
                                stat_code <= ST_RDY;
                                sw_cs     <= '0;
                                sw_we     <= 1'b0;
                                reset     <= 1'b0;
                            end else begin
                                sweep <= sweep + AW'(1);
                                if (seed_mode) wdat <= wdat + N_DATA_BITS'(1);
                            end
                        end
                    end
                    default: begin
                        state     <= StReady;
                        stat_code <= ST_RDY;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_nx_indirect_access_cntrl_v3.sv
// Directed self-checking bench for nx_indirect_access_cntrl_v3 (non-REG memory, 16 entries).
module tb_nx_indirect_access_cntrl_v3;

    localparam logic [15:0] CMD = 16'h0010;
    localparam logic [31:0] RDATA = 32'hDEAD_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_stb = 1'b0;
    logic [15:0] reg_addr = CMD;
    logic [3:0]  cmnd_op = 4'h0;
    logic [3:0]  cmnd_addr = '0;
    logic [1:0]  cmnd_table_id = '0;
    logic [15:0] addr_limit = 16'hFFFF;
    logic [31:0] wr_dat = '0;
    logic [2:0]  stat_code;
    logic [3:0]  stat_ptr;
    logic [7:0]  err_cnt;
    logic        enable;
    logic [31:0] rd_dat;
    logic [3:0]  sw_cs;
    logic        sw_we, sw_ce;
    logic [3:0]  sw_add;
    logic [31:0] sw_wdat;
    logic [31:0] sw_rdat = '0;
    logic        sw_match = 1'b0;
    logic [3:0]  sw_aindex = '0;
    logic        grant = 1'b0;
    logic        rsp = 1'b0;
    logic        yield, reset;

    int n_cmp = 0;
    int n_fail = 0;

    nx_indirect_access_cntrl_v3 #(
        .MEM_TYPE(1), .CMND_ADDRESS(16), .N_TIMER_BITS(6), .N_REG_ADDR_BITS(16),
        .N_DATA_BITS(32), .N_TABLES(4), .N_ENTRIES(16), .N_ERR_BITS(8), .RESET_DATA(RDATA)
    ) dut (
        .clk(clk), .rst(rst), .wr_stb(wr_stb), .reg_addr(reg_addr), .cmnd_op(cmnd_op),
        .cmnd_addr(cmnd_addr), .cmnd_table_id(cmnd_table_id), .addr_limit(addr_limit),
        .wr_dat(wr_dat), .stat_code(stat_code), .stat_ptr(stat_ptr), .err_cnt(err_cnt),
        .enable(enable), .rd_dat(rd_dat), .sw_cs(sw_cs), .sw_we(sw_we), .sw_ce(sw_ce),
        .sw_add(sw_add), .sw_wdat(sw_wdat), .sw_rdat(sw_rdat), .sw_match(sw_match),
        .sw_aindex(sw_aindex), .grant(grant), .rsp(rsp), .yield(yield), .reset(reset)
    );

    always #5 clk = ~clk;

    // Drives one command write at a negedge; returns at the next negedge (cycle T+1).
    task automatic issue(input logic [3:0] op, input logic [1:0] t, input logic [3:0] a,
                         input logic [31:0] d);
        wr_stb = 1'b1; reg_addr = CMD; cmnd_op = op;
        cmnd_table_id = t; cmnd_addr = a; wr_dat = d;
        @(negedge clk);
        wr_stb = 1'b0; cmnd_op = 4'h0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (stat_code !== 3'd7) begin n_fail++; $display("FAIL rst_stat got %0d want 7", stat_code); end
        n_cmp++; if (enable !== 1'b0) begin n_fail++; $display("FAIL rst_enable got %b want 0", enable); end
        n_cmp++; if (rd_dat !== RDATA) begin n_fail++; $display("FAIL rst_rd_dat got %h want %h", rd_dat, RDATA); end
        n_cmp++; if ({sw_cs, sw_we, sw_ce, reset, yield} !== 8'h00) begin n_fail++; $display("FAIL rst_ctrl got %b want 00000000", {sw_cs, sw_we, sw_ce, reset, yield}); end
        n_cmp++; if ({err_cnt, stat_ptr} !== 12'h000) begin n_fail++; $display("FAIL rst_cnt_ptr got %h want 000", {err_cnt, stat_ptr}); end
    endtask

    task automatic test_enable_write();
        issue(4'h3, 2'd0, 4'd0, 32'h0);
        n_cmp++; if (stat_code !== 3'd0) begin n_fail++; $display("FAIL en_stat got %0d want 0", stat_code); end
        n_cmp++; if (enable !== 1'b1) begin n_fail++; $display("FAIL en_enable got %b want 1", enable); end
        issue(4'h2, 2'd2, 4'd5, 32'hA5);
        n_cmp++; if (stat_code !== 3'd1) begin n_fail++; $display("FAIL wr_bsy got %0d want 1", stat_code); end
        n_cmp++; if ({sw_cs, sw_we, sw_ce} !== 6'b0100_10) begin n_fail++; $display("FAIL wr_cs_we got %b want 010010", {sw_cs, sw_we, sw_ce}); end
        n_cmp++; if ({sw_add, sw_wdat} !== {4'd5, 32'hA5}) begin n_fail++; $display("FAIL wr_add_dat got %h/%h want 5/a5", sw_add, sw_wdat); end
        grant = 1'b1;
        @(negedge clk);
        grant = 1'b0;
        n_cmp++; if ({stat_code, sw_cs, sw_we} !== 8'h00) begin n_fail++; $display("FAIL wr_done got %0d/%b/%b want 0/0000/0", stat_code, sw_cs, sw_we); end
    endtask

    task automatic test_reset_sweep();
        int cnt;
        cnt = 0;
        addr_limit = {4'd15, 4'd15, 4'd3, 4'd15};
        grant = 1'b1;
        issue(4'h5, 2'd1, 4'd0, 32'h0);
        for (int i = 0; i < 8; i++) begin
            if (reset === 1'b1) begin
                n_cmp++;
                if ({sw_add, sw_cs, sw_we, sw_wdat} !== {4'(cnt), 4'b0010, 1'b1, RDATA}) begin
                    n_fail++;
                    $display("FAIL sweep_%0d got %h/%b/%b/%h want %0d/0010/1/%h", cnt, sw_add, sw_cs, sw_we, sw_wdat, cnt, RDATA);
                end
                cnt++;
            end
            @(negedge clk);
        end
        grant = 1'b0;
        n_cmp++; if (cnt !== 4) begin n_fail++; $display("FAIL sweep_len got %0d want 4", cnt); end
        n_cmp++; if ({stat_code, sw_cs} !== 7'h00) begin n_fail++; $display("FAIL sweep_end got %0d/%b want 0/0000", stat_code, sw_cs); end
    endtask

    task automatic test_ptr_inc();
        logic [3:0] exp_add [3];
        exp_add[0] = 4'd2; exp_add[1] = 4'd3; exp_add[2] = 4'd0;
        issue(4'hA, 2'd1, 4'd2, 32'h0);
        n_cmp++; if ({stat_code, stat_ptr} !== {3'd0, 4'd2}) begin n_fail++; $display("FAIL setptr got %0d/%0d want 0/2", stat_code, stat_ptr); end
        grant = 1'b1;
        for (int i = 0; i < 3; i++) begin
            issue(4'hC, 2'd1, 4'd9, 32'h11 + i);
            n_cmp++; if ({sw_add, sw_we} !== {exp_add[i], 1'b1}) begin n_fail++; $display("FAIL winc_%0d got %0d/%b want %0d/1", i, sw_add, sw_we, exp_add[i]); end
            @(negedge clk);
        end
        grant = 1'b0;
        n_cmp++; if ({stat_code, stat_ptr} !== {3'd0, 4'd1}) begin n_fail++; $display("FAIL winc_ptr got %0d/%0d want 0/1", stat_code, stat_ptr); end
    endtask

    task automatic test_nxm();
        addr_limit = {4'd15, 4'd15, 4'd3, 4'd7};
        issue(4'h1, 2'd0, 4'd9, 32'h0);
        n_cmp++; if ({stat_code, err_cnt, sw_cs} !== {3'd4, 8'd1, 4'b0000}) begin n_fail++; $display("FAIL nxm got %0d/%0d/%b want 4/1/0000", stat_code, err_cnt, sw_cs); end
        issue(4'hF, 2'd0, 4'd0, 32'h0);
        n_cmp++; if (stat_code !== 3'd0) begin n_fail++; $display("FAIL nxm_ack got %0d want 0", stat_code); end
    endtask

    task automatic test_read_compare();
        issue(4'h1, 2'd3, 4'd4, 32'h0);
        n_cmp++; if ({stat_code, sw_cs, sw_add, sw_we} !== {3'd1, 4'b1000, 4'd4, 1'b0}) begin n_fail++; $display("FAIL rd_issue got %0d/%b/%0d/%b want 1/1000/4/0", stat_code, sw_cs, sw_add, sw_we); end
        grant = 1'b1;
        @(negedge clk);
        grant = 1'b0;
        n_cmp++; if ({stat_code, sw_cs} !== {3'd1, 4'b0000}) begin n_fail++; $display("FAIL rd_wait got %0d/%b want 1/0000", stat_code, sw_cs); end
        sw_rdat = 32'h1234_5678; rsp = 1'b1;
        @(negedge clk);
        rsp = 1'b0;
        n_cmp++; if ({stat_code, rd_dat} !== {3'd0, 32'h1234_5678}) begin n_fail++; $display("FAIL rd_data got %0d/%h want 0/12345678", stat_code, rd_dat); end
        sw_match = 1'b1; sw_aindex = 4'd6;
        issue(4'h9, 2'd0, 4'd2, 32'hCAFE);
        n_cmp++; if ({sw_ce, sw_we, sw_cs, sw_wdat} !== {1'b1, 1'b0, 4'b0001, 32'hCAFE}) begin n_fail++; $display("FAIL cmp_issue got %b/%b/%b/%h want 1/0/0001/cafe", sw_ce, sw_we, sw_cs, sw_wdat); end
        grant = 1'b1;
        @(negedge clk);
        grant = 1'b0; rsp = 1'b1;
        @(negedge clk);
        rsp = 1'b0; sw_match = 1'b0;
        n_cmp++; if ({stat_code, rd_dat} !== {3'd0, 32'h16}) begin n_fail++; $display("FAIL cmp_data got %0d/%h want 0/16", stat_code, rd_dat); end
    endtask

    task automatic test_timeout();
        grant = 1'b1;
        issue(4'hE, 2'd0, 4'd0, 32'h0);
        issue(4'h1, 2'd0, 4'd1, 32'h0);
        for (int k = 1; k <= 64; k++) begin
            if (k == 32) begin
                n_cmp++; if (yield !== 1'b0) begin n_fail++; $display("FAIL tmo_yield32 got %b want 0", yield); end
            end
            if (k == 33) begin
                n_cmp++; if (yield !== 1'b1) begin n_fail++; $display("FAIL tmo_yield33 got %b want 1", yield); end
            end
            if (k == 63) begin
                n_cmp++; if ({stat_code, sw_cs} !== {3'd1, 4'b0001}) begin n_fail++; $display("FAIL tmo_busy got %0d/%b want 1/0001", stat_code, sw_cs); end
            end
            if (k == 64) begin
                n_cmp++; if ({stat_code, err_cnt, sw_cs} !== {3'd2, 8'd2, 4'b0000}) begin n_fail++; $display("FAIL tmo_hit got %0d/%0d/%b want 2/2/0000", stat_code, err_cnt, sw_cs); end
            end
            if (k < 64) @(negedge clk);
        end
        issue(4'hF, 2'd0, 4'd0, 32'h0);
        // Suppression ends with the timeout, so a plain write now completes on grant.
        issue(4'h2, 2'd0, 4'd1, 32'h0);
        @(negedge clk);
        grant = 1'b0;
        n_cmp++; if (stat_code !== 3'd0) begin n_fail++; $display("FAIL tmo_after got %0d want 0", stat_code); end
    endtask

    task automatic test_ovr_saturate();
        issue(4'h1, 2'd0, 4'd1, 32'h0);
        issue(4'h2, 2'd0, 4'd1, 32'h0);
        n_cmp++; if ({stat_code, err_cnt, sw_cs} !== {3'd3, 8'd3, 4'b0000}) begin n_fail++; $display("FAIL ovr got %0d/%0d/%b want 3/3/0000", stat_code, err_cnt, sw_cs); end
        issue(4'hF, 2'd0, 4'd0, 32'h0);
        for (int i = 0; i < 260; i++) begin
            issue(4'hD, 2'd0, 4'd0, 32'h0);
            if (i == 0) begin
                n_cmp++; if ({stat_code, err_cnt} !== {3'd5, 8'd4}) begin n_fail++; $display("FAIL uop got %0d/%0d want 5/4", stat_code, err_cnt); end
            end
            issue(4'hF, 2'd0, 4'd0, 32'h0);
        end
        n_cmp++; if ({stat_code, err_cnt} !== {3'd0, 8'd255}) begin n_fail++; $display("FAIL err_sat got %0d/%0d want 0/255", stat_code, err_cnt); end
    endtask

    task automatic test_disable_abort();
        issue(4'h4, 2'd0, 4'd0, 32'h0);
        n_cmp++; if ({stat_code, enable} !== {3'd7, 1'b0}) begin n_fail++; $display("FAIL dis got %0d/%b want 7/0", stat_code, enable); end
        issue(4'h1, 2'd0, 4'd1, 32'h0);
        n_cmp++; if ({stat_code, sw_cs} !== {3'd7, 4'b0000}) begin n_fail++; $display("FAIL dis_rd got %0d/%b want 7/0000", stat_code, sw_cs); end
        issue(4'h3, 2'd0, 4'd0, 32'h0);
        issue(4'h5, 2'd1, 4'd0, 32'h0);
        @(negedge clk);
        n_cmp++; if ({reset, sw_cs} !== {1'b1, 4'b0010}) begin n_fail++; $display("FAIL abort_pre got %b/%b want 1/0010", reset, sw_cs); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if ({stat_code, reset, sw_cs, sw_we, err_cnt} !== {3'd7, 1'b0, 4'b0000, 1'b0, 8'd0}) begin n_fail++; $display("FAIL abort got %0d/%b/%b/%b/%0d want 7/0/0000/0/0", stat_code, reset, sw_cs, sw_we, err_cnt); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_enable_write();
        test_reset_sweep();
        test_ptr_inc();
        test_nxm();
        test_read_compare();
        test_timeout();
        test_ovr_saturate();
        test_disable_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
